// File: rtl/mcpu_core_hazard_issue_pkg.sv
// Shared definitions for the decode-side hazard/issue stage: lane geometry,
// the normalised lane record and the issue FSM state type.
package mcpu_core_hazard_issue_pkg;

    localparam int LANES    = 4;
    localparam int NUM_PRED = 3;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int PRED_W   = 2;

    localparam logic [PRED_W-1:0] PRED_ALWAYS = 2'd3;

    typedef struct packed {
        logic [REG_W-1:0]  rs_num;
        logic [REG_W-1:0]  rt_num;
        logic [REG_W-1:0]  rd_num;
        logic              rs_re;
        logic              rt_re;
        logic              rd_we;
        logic [PRED_W-1:0] pred_num;
        logic              pred_we;
    } lane_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // r0 is hardwired zero, so reading or writing it can never create a dependency.
    function automatic lane_t normalise_lane(lane_t raw);
        lane_t n;
        n       = raw;
        n.rs_re = raw.rs_re & (raw.rs_num != '0);
        n.rt_re = raw.rt_re & (raw.rt_num != '0);
        n.rd_we = raw.rd_we & (raw.rd_num != '0);
        return n;
    endfunction

endpackage

// File: rtl/mcpu_core_hazard_issue_if.sv
// Bundle of fetch, scoreboard and pipeline-controller signals seen by the
// hazard/issue stage; lane i of each packed number field sits at [W*i +: W].
interface mcpu_core_hazard_issue_if #(
    parameter int STALL_CNT_W = 16
);
    import mcpu_core_hazard_issue_pkg::*;

    logic                      f2d_valid;
    logic                      d2f_ready;
    logic [LANES*REG_W-1:0]    f2d_rs_num;
    logic [LANES*REG_W-1:0]    f2d_rt_num;
    logic [LANES*REG_W-1:0]    f2d_rd_num;
    logic [LANES-1:0]          f2d_rs_re;
    logic [LANES-1:0]          f2d_rt_re;
    logic [LANES-1:0]          f2d_rd_we;
    logic [LANES*PRED_W-1:0]   f2d_pred_num;
    logic [LANES-1:0]          f2d_pred_we;
    logic [NUM_REGS-1:0]       sb2d_reg_scoreboard;
    logic [NUM_PRED-1:0]       sb2d_pred_scoreboard;
    logic                      pc2d_ready;
    logic                      pc2d_flush;
    logic                      d2pc_progress;
    logic [REG_W-1:0]          d2pc_out_rd_num0, d2pc_out_rd_num1, d2pc_out_rd_num2, d2pc_out_rd_num3;
    logic                      d2pc_out_rd_we0, d2pc_out_rd_we1, d2pc_out_rd_we2, d2pc_out_rd_we3;
    logic                      d2pc_out_pred_we0, d2pc_out_pred_we1, d2pc_out_pred_we2, d2pc_out_pred_we3;
    logic [STALL_CNT_W-1:0]    d2pc_stall_count;

    modport master (
        output f2d_valid, f2d_rs_num, f2d_rt_num, f2d_rd_num, f2d_rs_re, f2d_rt_re,
               f2d_rd_we, f2d_pred_num, f2d_pred_we, sb2d_reg_scoreboard,
               sb2d_pred_scoreboard, pc2d_ready, pc2d_flush,
        input  d2f_ready, d2pc_progress,
               d2pc_out_rd_num0, d2pc_out_rd_num1, d2pc_out_rd_num2, d2pc_out_rd_num3,
               d2pc_out_rd_we0, d2pc_out_rd_we1, d2pc_out_rd_we2, d2pc_out_rd_we3,
               d2pc_out_pred_we0, d2pc_out_pred_we1, d2pc_out_pred_we2, d2pc_out_pred_we3,
               d2pc_stall_count
    );

    modport slave (
        input  f2d_valid, f2d_rs_num, f2d_rt_num, f2d_rd_num, f2d_rs_re, f2d_rt_re,
               f2d_rd_we, f2d_pred_num, f2d_pred_we, sb2d_reg_scoreboard,
               sb2d_pred_scoreboard, pc2d_ready, pc2d_flush,
        output d2f_ready, d2pc_progress,
               d2pc_out_rd_num0, d2pc_out_rd_num1, d2pc_out_rd_num2, d2pc_out_rd_num3,
               d2pc_out_rd_we0, d2pc_out_rd_we1, d2pc_out_rd_we2, d2pc_out_rd_we3,
               d2pc_out_pred_we0, d2pc_out_pred_we1, d2pc_out_pred_we2, d2pc_out_pred_we3,
               d2pc_stall_count
    );

endinterface

// File: rtl/mcpu_core_hazard_issue_lane.sv
// Combinational hazard check of one held lane against the register and
// predicate scoreboards (RAW on sources/guard, WAW on destinations).
module mcpu_core_hazard_lane
    import mcpu_core_hazard_issue_pkg::*;
(
    input  lane_t               lane_i,
    input  logic [NUM_REGS-1:0] reg_sb_i,
    input  logic [NUM_PRED-1:0] pred_sb_i,
    output logic                hazard_o
);

    // Predicate 3 is always-true and never busy: pad the busy vector with a 0 at index 3.
    logic [(1<<PRED_W)-1:0] pred_busy;
    logic                   rs_haz, rt_haz, rd_haz, guard_haz, pwr_haz;

    assign pred_busy = {1'b0, pred_sb_i};

    assign rs_haz    = lane_i.rs_re & reg_sb_i[lane_i.rs_num];
    assign rt_haz    = lane_i.rt_re & reg_sb_i[lane_i.rt_num];
    assign rd_haz    = lane_i.rd_we & reg_sb_i[lane_i.rd_num];
    assign guard_haz = (lane_i.pred_num != PRED_ALWAYS) & pred_busy[lane_i.pred_num];
    assign pwr_haz   = lane_i.pred_we & pred_busy[lane_i.rd_num[PRED_W-1:0]];

    assign hazard_o  = rs_haz | rt_haz | rd_haz | guard_haz | pwr_haz;

endmodule

// File: rtl/mcpu_core_hazard_issue.sv
// Single-entry decode holding stage: captures a 4-lane packet from fetch and
// pulses d2pc_progress once no lane conflicts with the scoreboards.
module mcpu_core_hazard_issue
    import mcpu_core_hazard_issue_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clkrst_core_clk,
    input  logic                    clkrst_core_rst_n,
    mcpu_core_hazard_issue_if.slave bus_io
);

    state_e                     state_q, state_d;
    lane_t [LANES-1:0]          pkt_q, pkt_d, in_pkt;
    logic  [STALL_CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic  [LANES-1:0]          lane_hazard, out_rd_we, out_pred_we;
    logic  [LANES-1:0][REG_W-1:0] out_rd_num;
    logic                       full, hazard, issue, ready, accept;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_t raw;
        assign raw = '{
            rs_num:   bus_io.f2d_rs_num[g*REG_W +: REG_W],
            rt_num:   bus_io.f2d_rt_num[g*REG_W +: REG_W],
            rd_num:   bus_io.f2d_rd_num[g*REG_W +: REG_W],
            rs_re:    bus_io.f2d_rs_re[g],
            rt_re:    bus_io.f2d_rt_re[g],
            rd_we:    bus_io.f2d_rd_we[g],
            pred_num: bus_io.f2d_pred_num[g*PRED_W +: PRED_W],
            pred_we:  bus_io.f2d_pred_we[g]
        };
        assign in_pkt[g] = normalise_lane(raw);

        mcpu_core_hazard_lane u_lane (
            .lane_i    (pkt_q[g]),
            .reg_sb_i  (bus_io.sb2d_reg_scoreboard),
            .pred_sb_i (bus_io.sb2d_pred_scoreboard),
            .hazard_o  (lane_hazard[g])
        );

        // Gated by held-valid so an empty stage never marks the scoreboard.
        assign out_rd_num[g]  = full ? pkt_q[g].rd_num : '0;
        assign out_rd_we[g]   = full & pkt_q[g].rd_we;
        assign out_pred_we[g] = full & pkt_q[g].pred_we;
    end

    assign full   = (state_q == ST_FULL);
    assign hazard = |lane_hazard;
    assign issue  = full & ~hazard & bus_io.pc2d_ready & ~bus_io.pc2d_flush;
    assign ready  = ~bus_io.pc2d_flush & (~full | issue);
    assign accept = ready & bus_io.f2d_valid;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        stall_cnt_d = stall_cnt_q;
        if (full & hazard & ~bus_io.pc2d_flush & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
        if (bus_io.pc2d_flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
            pkt_d   = in_pkt;
        end else if (issue) begin
            state_d = ST_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_q     <= ST_EMPTY;
            pkt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Fetch must not see ready while reset holds the stage, even though EMPTY would otherwise accept.
    assign bus_io.d2f_ready         = clkrst_core_rst_n & ready;
    assign bus_io.d2pc_progress     = issue;
    assign bus_io.d2pc_stall_count  = stall_cnt_q;
    assign bus_io.d2pc_out_rd_num0  = out_rd_num[0];
    assign bus_io.d2pc_out_rd_num1  = out_rd_num[1];
    assign bus_io.d2pc_out_rd_num2  = out_rd_num[2];
    assign bus_io.d2pc_out_rd_num3  = out_rd_num[3];
    assign bus_io.d2pc_out_rd_we0   = out_rd_we[0];
    assign bus_io.d2pc_out_rd_we1   = out_rd_we[1];
    assign bus_io.d2pc_out_rd_we2   = out_rd_we[2];
    assign bus_io.d2pc_out_rd_we3   = out_rd_we[3];
    assign bus_io.d2pc_out_pred_we0 = out_pred_we[0];
    assign bus_io.d2pc_out_pred_we1 = out_pred_we[1];
    assign bus_io.d2pc_out_pred_we2 = out_pred_we[2];
    assign bus_io.d2pc_out_pred_we3 = out_pred_we[3];

endmodule

// File: tb/tb_mcpu_core_hazard_issue.sv
// Self-checking bench: a packet-level model predicts every output each cycle,
// and directed scenarios pin hand-computed values for the key cases.
module tb_mcpu_core_hazard_issue;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int NL      = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    mcpu_core_hazard_issue_if #(.STALL_CNT_W(CW)) bus ();

    mcpu_core_hazard_issue #(.STALL_CNT_W(CW)) dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .bus_io            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    int m_rs[NL], m_rt[NL], m_rd[NL], m_pred[NL];
    bit m_rs_re[NL], m_rt_re[NL], m_rd_we[NL], m_pwe[NL];
    bit m_full;
    int m_cnt;

    function automatic bit model_hazard();
        bit h = 0;
        for (int l = 0; l < NL; l++) begin
            if (m_rs_re[l] && bus.sb2d_reg_scoreboard[m_rs[l]]) h = 1;
            if (m_rt_re[l] && bus.sb2d_reg_scoreboard[m_rt[l]]) h = 1;
            if (m_rd_we[l] && bus.sb2d_reg_scoreboard[m_rd[l]]) h = 1;
            if (m_pred[l] != 3 && bus.sb2d_pred_scoreboard[m_pred[l]]) h = 1;
            if (m_pwe[l] && (m_rd[l] % 4) != 3 && bus.sb2d_pred_scoreboard[m_rd[l] % 4]) h = 1;
        end
        return h;
    endfunction

    function automatic bit model_issue();
        return m_full && !model_hazard() && bus.pc2d_ready && !bus.pc2d_flush;
    endfunction

    function automatic bit model_ready();
        return !bus.pc2d_flush && (!m_full || model_issue());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 0;
            m_cnt  = 0;
            for (int l = 0; l < NL; l++) begin
                m_rs[l] = 0; m_rt[l] = 0; m_rd[l] = 0; m_pred[l] = 0;
                m_rs_re[l] = 0; m_rt_re[l] = 0; m_rd_we[l] = 0; m_pwe[l] = 0;
            end
        end else begin
            bit iss, rdy;
            iss = model_issue();
            rdy = model_ready();
            if (m_full && model_hazard() && !bus.pc2d_flush && m_cnt < CNT_MAX) m_cnt++;
            if (bus.pc2d_flush) begin
                m_full = 0;
            end else if (rdy && bus.f2d_valid) begin
                for (int l = 0; l < NL; l++) begin
                    m_rs[l]    = int'(bus.f2d_rs_num[l*5 +: 5]);
                    m_rt[l]    = int'(bus.f2d_rt_num[l*5 +: 5]);
                    m_rd[l]    = int'(bus.f2d_rd_num[l*5 +: 5]);
                    m_pred[l]  = int'(bus.f2d_pred_num[l*2 +: 2]);
                    m_rs_re[l] = bus.f2d_rs_re[l] && m_rs[l] != 0;
                    m_rt_re[l] = bus.f2d_rt_re[l] && m_rt[l] != 0;
                    m_rd_we[l] = bus.f2d_rd_we[l] && m_rd[l] != 0;
                    m_pwe[l]   = bus.f2d_pred_we[l];
                end
                m_full = 1;
            end else if (iss) begin
                m_full = 0;
            end
        end
    end

    function automatic logic [4:0] dut_rd_num(input int l);
        case (l)
            0: return bus.d2pc_out_rd_num0;
            1: return bus.d2pc_out_rd_num1;
            2: return bus.d2pc_out_rd_num2;
            default: return bus.d2pc_out_rd_num3;
        endcase
    endfunction

    function automatic logic dut_rd_we(input int l);
        case (l)
            0: return bus.d2pc_out_rd_we0;
            1: return bus.d2pc_out_rd_we1;
            2: return bus.d2pc_out_rd_we2;
            default: return bus.d2pc_out_rd_we3;
        endcase
    endfunction

    function automatic logic dut_pred_we(input int l);
        case (l)
            0: return bus.d2pc_out_pred_we0;
            1: return bus.d2pc_out_pred_we1;
            2: return bus.d2pc_out_pred_we2;
            default: return bus.d2pc_out_pred_we3;
        endcase
    endfunction

    // Single compare process: every cycle out of reset, all outputs vs. model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_ready", bus.d2f_ready, model_ready());
            check("m_progress", bus.d2pc_progress, model_issue());
            check("m_stall_count", bus.d2pc_stall_count, m_cnt);
            for (int l = 0; l < NL; l++) begin
                check($sformatf("m_rd_num%0d", l), dut_rd_num(l), m_full ? m_rd[l] : 0);
                check($sformatf("m_rd_we%0d", l), dut_rd_we(l), m_full && m_rd_we[l]);
                check($sformatf("m_pred_we%0d", l), dut_pred_we(l), m_full && m_pwe[l]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic clear_lanes();
        bus.f2d_rs_num   = '0;
        bus.f2d_rt_num   = '0;
        bus.f2d_rd_num   = '0;
        bus.f2d_rs_re    = '0;
        bus.f2d_rt_re    = '0;
        bus.f2d_rd_we    = '0;
        bus.f2d_pred_num = 8'hFF;
        bus.f2d_pred_we  = '0;
    endtask

    task automatic set_lane(input int l, input int rs, input int rt, input int rd,
                            input bit rs_re, input bit rt_re, input bit rd_we,
                            input int pred, input bit pwe);
        bus.f2d_rs_num[l*5 +: 5]   = rs[4:0];
        bus.f2d_rt_num[l*5 +: 5]   = rt[4:0];
        bus.f2d_rd_num[l*5 +: 5]   = rd[4:0];
        bus.f2d_rs_re[l]           = rs_re;
        bus.f2d_rt_re[l]           = rt_re;
        bus.f2d_rd_we[l]           = rd_we;
        bus.f2d_pred_num[l*2 +: 2] = pred[1:0];
        bus.f2d_pred_we[l]         = pwe;
    endtask

    task automatic idle_inputs();
        clear_lanes();
        bus.f2d_valid            = 1'b0;
        bus.sb2d_reg_scoreboard  = '0;
        bus.sb2d_pred_scoreboard = '0;
        bus.pc2d_ready           = 1'b1;
        bus.pc2d_flush           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.d2f_ready, 0);
        check("rst_progress", bus.d2pc_progress, 0);
        check("rst_count", bus.d2pc_stall_count, 0);
        check("rst_rd_we0", bus.d2pc_out_rd_we0, 0);
        rst_n = 1'b1;
    endtask

    task automatic flush_one();
        bus.pc2d_flush = 1'b1;
        next_cycle();
        bus.pc2d_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Independent back-to-back packets.
        do_reset();
        set_lane(0, 0, 0, 5, 0, 0, 1, 3, 0);
        bus.f2d_valid = 1'b1;
        at_neg();
        check("t1_ready_after_reset", bus.d2f_ready, 1);
        next_cycle();
        set_lane(0, 0, 0, 9, 0, 0, 1, 3, 0);
        at_neg();
        check("t1_progress_a", bus.d2pc_progress, 1);
        check("t1_rd_num0_a", bus.d2pc_out_rd_num0, 5);
        check("t1_rd_we0_a", bus.d2pc_out_rd_we0, 1);
        next_cycle();
        bus.f2d_valid = 1'b0;
        at_neg();
        check("t1_progress_b", bus.d2pc_progress, 1);
        check("t1_rd_num0_b", bus.d2pc_out_rd_num0, 9);
        next_cycle();
        at_neg();
        check("t1_empty_progress", bus.d2pc_progress, 0);
        check("t1_empty_rd_we0", bus.d2pc_out_rd_we0, 0);

        // RAW stall on lane1 rs=7 for three cycles.
        do_reset();
        set_lane(1, 7, 0, 0, 1, 0, 0, 3, 0);
        bus.sb2d_reg_scoreboard[7] = 1'b1;
        bus.f2d_valid = 1'b1;
        next_cycle();
        bus.f2d_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check($sformatf("t2_stall%0d", i), bus.d2pc_progress, 0);
            next_cycle();
        end
        bus.sb2d_reg_scoreboard = '0;
        at_neg();
        check("t2_issue", bus.d2pc_progress, 1);
        check("t2_count", bus.d2pc_stall_count, 3);
        next_cycle();

        // Predicate guard, always-true guard, predicate write hazards.
        do_reset();
        set_lane(0, 0, 0, 0, 0, 0, 0, 2, 0);
        bus.sb2d_pred_scoreboard = 3'b100;
        bus.f2d_valid = 1'b1;
        next_cycle();
        bus.f2d_valid = 1'b0;
        at_neg();
        check("t3_guard_stall", bus.d2pc_progress, 0);
        next_cycle();
        flush_one();
        set_lane(0, 0, 0, 0, 0, 0, 0, 3, 0);
        bus.f2d_valid = 1'b1;
        next_cycle();
        clear_lanes();
        set_lane(0, 0, 0, 4, 0, 0, 0, 3, 1);
        bus.sb2d_pred_scoreboard = 3'b001;
        at_neg();
        check("t3_always_issue", bus.d2pc_progress, 1);
        next_cycle();
        bus.f2d_valid = 1'b0;
        at_neg();
        check("t3_pwe_stall", bus.d2pc_progress, 0);
        check("t3_pred_we0", bus.d2pc_out_pred_we0, 1);
        next_cycle();
        flush_one();
        set_lane(0, 0, 0, 7, 0, 0, 0, 3, 1);
        bus.sb2d_pred_scoreboard = 3'b111;
        bus.f2d_valid = 1'b1;
        next_cycle();
        bus.f2d_valid = 1'b0;
        at_neg();
        check("t3_pwe_p3_no_hazard", bus.d2pc_progress, 1);
        next_cycle();

        // r0 normalisation.
        do_reset();
        set_lane(2, 0, 0, 0, 1, 0, 1, 3, 0);
        bus.sb2d_reg_scoreboard = 32'h1;
        bus.f2d_valid = 1'b1;
        next_cycle();
        bus.f2d_valid = 1'b0;
        at_neg();
        check("t4_r0_no_stall", bus.d2pc_progress, 1);
        check("t4_r0_rd_we2", bus.d2pc_out_rd_we2, 0);
        next_cycle();

        // Flush of a stalled packet while fetch offers another.
        do_reset();
        set_lane(0, 3, 0, 8, 1, 0, 1, 3, 0);
        bus.sb2d_reg_scoreboard = 32'h8;
        bus.f2d_valid = 1'b1;
        next_cycle();
        clear_lanes();
        set_lane(0, 0, 0, 11, 0, 0, 1, 3, 0);
        at_neg();
        check("t5_hazard_ready", bus.d2f_ready, 0);
        next_cycle();
        bus.pc2d_flush = 1'b1;
        at_neg();
        check("t5_flush_progress", bus.d2pc_progress, 0);
        check("t5_flush_ready", bus.d2f_ready, 0);
        next_cycle();
        bus.pc2d_flush = 1'b0;
        bus.f2d_valid  = 1'b0;
        at_neg();
        check("t5_after_ready", bus.d2f_ready, 1);
        check("t5_after_rd_we0", bus.d2pc_out_rd_we0, 0);
        check("t5_after_count", bus.d2pc_stall_count, 1);
        next_cycle();

        // Backpressure without hazard does not count as a stall.
        do_reset();
        set_lane(3, 0, 0, 12, 0, 0, 1, 3, 0);
        bus.pc2d_ready = 1'b0;
        bus.f2d_valid  = 1'b1;
        next_cycle();
        bus.f2d_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check($sformatf("t6_held_progress%0d", i), bus.d2pc_progress, 0);
            check($sformatf("t6_held_rd_num3_%0d", i), bus.d2pc_out_rd_num3, 12);
            check($sformatf("t6_held_count%0d", i), bus.d2pc_stall_count, 0);
            next_cycle();
        end
        bus.pc2d_ready = 1'b1;
        at_neg();
        check("t6_release", bus.d2pc_progress, 1);
        next_cycle();

        // Counter saturation, then reset while FULL.
        do_reset();
        set_lane(0, 0, 10, 6, 0, 1, 1, 3, 0);
        bus.sb2d_reg_scoreboard = 32'h400;
        bus.f2d_valid = 1'b1;
        next_cycle();
        bus.f2d_valid = 1'b0;
        repeat (20) next_cycle();
        at_neg();
        check("t7_saturated", bus.d2pc_stall_count, 15);
        check("t7_held_rd_we0", bus.d2pc_out_rd_we0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_midrst_rd_we0", bus.d2pc_out_rd_we0, 0);
        check("t7_midrst_rd_num0", bus.d2pc_out_rd_num0, 0);
        check("t7_midrst_progress", bus.d2pc_progress, 0);
        check("t7_midrst_ready", bus.d2f_ready, 0);
        check("t7_midrst_count", bus.d2pc_stall_count, 0);

        // Mixed multi-lane traffic checked against the model only.
        do_reset();
        for (int c = 0; c < 120; c++) begin
            for (int l = 0; l < NL; l++) begin
                set_lane(l, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
            bus.f2d_valid            = ($urandom_range(0, 3) != 0);
            bus.sb2d_reg_scoreboard  = $urandom & $urandom & $urandom;
            bus.sb2d_pred_scoreboard = 3'($urandom_range(0, 7) & $urandom_range(0, 7) & $urandom_range(0, 7));
            bus.pc2d_ready           = ($urandom_range(0, 3) != 0);
            bus.pc2d_flush           = ($urandom_range(0, 15) == 0);
            next_cycle();
        end
        idle_inputs();
        at_neg();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mcpu_core_hazard_issue.md
Name: mcpu_core_hazard_issue

Overview:
- Decode-side consumer of the register/predicate scoreboard.
- Holds one decoded 4-lane instruction packet and checks its source and destination registers and predicates against `sb2d_reg_scoreboard` / `sb2d_pred_scoreboard`.
- Issues the packet downstream by pulsing `d2pc_progress`. That same pulse is what causes the scoreboard to mark the packet's destinations busy.
- Sits between fetch (valid/ready) and the pipeline controller (ready/progress).

Parameters:
- STALL_CNT_W, 16, width of the saturating hazard-stall performance counter.

Ports:
- clkrst_core_clk  in  1  core clock
- clkrst_core_rst_n  in  1  asynchronous active-low reset
- f2d_valid  in  1  fetch offers a decoded packet
- d2f_ready  out  1  packet accepted when f2d_valid & d2f_ready
- f2d_rs_num, f2d_rt_num, f2d_rd_num  in  20 each  5-bit register numbers, lane i at [5i+4:5i]
- f2d_rs_re, f2d_rt_re, f2d_rd_we  in  4 each  per-lane read/write enables
- f2d_pred_num  in  8  2-bit guard predicate per lane; value 3 = always-true, no dependency
- f2d_pred_we  in  4  lane writes predicate rd_num[1:0]
- sb2d_reg_scoreboard  in  32  busy bit per register
- sb2d_pred_scoreboard  in  3  busy bit per predicate p0..p2
- pc2d_ready  in  1  downstream can accept this cycle
- pc2d_flush  in  1  discard held packet (branch/exception)
- d2pc_progress  out  1  packet issues this cycle
- d2pc_out_rd_num0..3  out  5 each  destination register per lane
- d2pc_out_rd_we0..3, d2pc_out_pred_we0..3  out  1 each  write enables, gated by held-valid
- d2pc_stall_count  out  STALL_CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (async, active low):
  - state EMPTY; held packet cleared.
  - d2f_ready=0 during reset, 1 in the first cycle after reset.
  - d2pc_progress=0, all d2pc_out_* = 0, d2pc_stall_count=0.
- Capture: fields are normalised when the packet is captured.
  - rd_we is forced 0 when rd_num==0 (r0 hardwired zero).
  - rs_re/rt_re are forced 0 when the number is 0.
- States:
  - EMPTY:
    - d2f_ready=1.
    - f2d_valid -> capture packet, go to FULL.
  - FULL:
    - hazard = OR over lanes of:
      - rs_re & sb[rs]
      - rt_re & sb[rt]
      - rd_we & sb[rd] (WAW)
      - pred_num!=3 & psb[pred_num]
      - pred_we & psb[rd[1:0]], where rd[1:0]==3 never hazards
    - issue = ~hazard & pc2d_ready & ~pc2d_flush.
    - d2pc_progress = issue (combinational, from registered state and the scoreboard inputs).
    - d2f_ready = issue.
    - issue & f2d_valid -> capture the new packet, stay FULL (back-to-back, zero bubble).
    - issue & ~f2d_valid -> EMPTY.
    - otherwise hold the packet; d2pc_out_* remain stable.
- Back-to-back dependency: the scoreboard output reflects the issued destinations in the cycle after progress. A dependent packet captured on the issue edge therefore sees the busy bit and stalls. No internal bypass is required.
- Flush:
  - pc2d_flush has priority: d2pc_progress=0, d2f_ready=0, next state EMPTY.
  - A concurrently offered fetch packet is not accepted.
- Output gating: d2pc_out_*_we are driven 0 in EMPTY, so the scoreboard sees no spurious marks.
- Stall counter:
  - Increments on each FULL cycle with hazard=1 and no flush, regardless of pc2d_ready.
  - Saturates at all-ones; cleared only by reset.
- Intra-packet conflicts (two lanes writing the same rd) are decoder responsibility; no check is made here.

Decomposition:
- Shared core package:
  - lane count (4)
  - predicate count (3)
  - PRED_ALWAYS = 2'd3
  - lane field slice helper constants
- One natural sub-module: mcpu_core_hazard_lane.
  - Combinational per-lane hazard check against both scoreboards.
  - Instantiated 4 times; results are ORed.

Test Plan:
- Independent packets: scoreboard all 0, pc2d_ready=1, two consecutive packets.
  - -> progress high on 2 consecutive cycles.
  - -> d2pc_out_rd_num0 = 5 then 9, rd_we0=1.
- RAW stall: held lane1 rs=7, sb bit7=1 for 3 cycles, then 0.
  - -> progress=0 for 3 cycles and 1 on the 4th.
  - -> d2pc_stall_count=3.
- Predicate: lane0 pred_num=2 with psb=3'b100 -> stall.
  - Same packet with pred_num=3 -> issues immediately.
  - pred_we with rd=4 (p0) and psb[0]=1 -> stall.
- r0 handling: rd=0 with rd_we=1 -> d2pc_out_rd_we=0.
  - rs=0 with sb[0]=1 forced -> no stall.
- Flush: FULL with hazard, then pc2d_flush=1 with f2d_valid=1.
  - -> progress=0, d2f_ready=0, state EMPTY.
  - -> next cycle d2f_ready=1, outputs we=0.
- Backpressure/saturation: pc2d_ready=0, no hazard -> held, counter unchanged.
  - Forced hazard with STALL_CNT_W=4 for 20 cycles -> count = 15.
  - Reset asserted mid-FULL -> all outputs 0 immediately.
